inst_loader: RTL
================

Name: inst_loader

Overview:
- Instruction-memory stage that feeds the 8-bit single-cycle CPU core. It answers the core's `ReadAddress` with an `Instruction` byte in the same cycle.
- Owns a byte-stream program loader: a length byte followed by that many instruction bytes.
- Holds the core in reset (`cpu_reset`) until a complete program is resident.
- Runs on the board clock `clk`. `cpu_reset` drives the core's `Reset` input.

Parameters:
- DEPTH, 256, instruction memory depth in bytes (addressed by 8-bit ReadAddress).
- FILL, 8'h00, byte returned for addresses at or beyond the loaded program length, and while not in RUN.
- TIMEOUT, 1_000_000, max clk cycles allowed between accepted bytes in LEN/DATA before aborting.

Ports:
- clk  input  1  board clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle request to (re)start a program load.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid; a byte transfers on a cycle where s_valid && s_ready.
- s_ready  output  1  loader accepts a byte this cycle.
- ReadAddress  input  8  instruction address from core PC.
- Instruction  output  8  instruction byte for ReadAddress (combinational).
- cpu_reset  output  1  active-high reset to the core.
- loading  output  1  high in LEN or DATA.
- load_err  output  1  sticky: last load aborted by timeout.
- prog_len  output  9  length of the resident program (0..256).

Behaviour:
- Reset (async) state:
  - state=IDLE, cpu_reset=1, s_ready=0, loading=0, load_err=0, prog_len=0, byte counter=0, timeout counter=0.
  - The memory array is not cleared.
- States:
  - IDLE: s_ready=0, cpu_reset=1. Goes to LEN on load_start.
  - LEN: s_ready=1.
    - Accepted byte L sets target = (L==0) ? 256 : L.
    - Also clears byte counter and load_err, then goes to DATA.
  - DATA: s_ready=1.
    - Each accepted byte is written to mem[counter] and the counter increments.
    - The byte that makes counter==target goes to RUN on the next edge.
    - prog_len<=target is loaded on that same edge.
  - RUN: s_ready=0, cpu_reset=0 from the first RUN cycle. load_start goes to LEN.
- cpu_reset=1 in every state except RUN. A reload therefore re-resets the core.
- The new prog_len takes effect only on entry to RUN. During a reload, prog_len keeps its old value.
- load_start in LEN or DATA:
  - Restarts at LEN, discarding the byte counter.
  - Bytes already written stay in memory but are not counted.
  - If load_start and a valid transfer occur in the same cycle, load_start wins and the byte is dropped.
- Timeout:
  - The counter runs in LEN and DATA and clears on each accepted byte and on state entry.
  - When it reaches TIMEOUT-1: load_err<=1, state<=IDLE, prog_len<=0.
- Read path (combinational, zero latency, required because the core fetches and executes in one cycle):
  - Instruction = (state==RUN && ReadAddress < prog_len) ? mem[ReadAddress] : FILL.
  - The comparison uses 9-bit width, so prog_len=256 exposes all addresses.
- Memory:
  - One synchronous write port, used only in DATA.
  - Asynchronous read port.
  - No write occurs in RUN, so there is no read/write hazard.
- Wrap-around:
  - The counter is 9 bits. It cannot exceed target ≤256, so addresses 0..255 only.
  - The core's PC wrap from 8'hFF to 8'h00 is handled entirely by the core.

Decomposition:
- Shared package `cpu_pkg`:
  - State encoding: IDLE=2'd0, LEN=2'd1, DATA=2'd2, RUN=2'd3.
  - Instruction width 8 and FILL default.
- One sub-module `inst_mem`: DEPTH×8 array, synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata).
- Top of `inst_loader` holds the FSM, counters and the read-path masking.

Test Plan:
- Reset, then load_start, then stream 8'h03, 8'h45, 8'h8A, 8'hC1 back-to-back:
  - s_ready high for exactly 4 transfers.
  - cpu_reset falls one cycle after the last transfer; prog_len=3.
  - ReadAddress 0/1/2 → 45/8A/C1; ReadAddress 3 → 00.
- Length byte 8'h00 plus 256 bytes with value = address:
  - prog_len=256.
  - ReadAddress FF → FF, ReadAddress 00 → 00.
  - No write beyond index 255.
- s_valid toggled 1/0 every cycle while loading 2 bytes:
  - Only handshaked bytes are written; the count is correct; RUN is reached after the 2nd accepted data byte.
- TIMEOUT=16; send length 8'h05 and 2 data bytes, then idle 16 cycles:
  - load_err=1, state IDLE, cpu_reset=1, prog_len=0, Instruction=FILL.
  - A subsequent good load clears load_err.
- In RUN with prog_len=3, pulse load_start:
  - cpu_reset rises the next cycle; Instruction=FILL until the new load completes.
  - Then send length 8'h02 plus bytes 11, 22: prog_len=2; ReadAddress 2 → 00 even though the old byte C1 is still in memory.
- Assert Reset asynchronously mid-DATA, between clock edges:
  - cpu_reset=1, s_ready=0, loading=0 immediately.
  - After release, the FSM waits for load_start.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the instruction-memory stage that feeds the 8-bit core.
// Loader state encoding and instruction-byte width/default.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    RUN  = 2'd3
  } loadState_t;

  localparam int INST_W = 8;
  localparam logic [INST_W-1:0] FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/inst_mem.sv
// Instruction byte store: one synchronous write port, one asynchronous read port.
// Contents survive reset; only the loader's DATA phase writes.
module inst_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_loader.sv
// Program loader + zero-latency instruction fetch for the single-cycle core.
// Receives a length byte then that many bytes, holding the core in reset until the program is resident.
//
// state | meaning
// IDLE  | no valid program, core held in reset, waiting for load_start
// LEN   | waiting for the length byte (0 means 256)
// DATA  | writing program bytes to mem[0..target-1]
// RUN   | program resident, core released, fetches served from memory
module inst_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter logic [INST_W-1:0] FILL = FILL_DEFAULT,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        ReadAddress,
  output logic [INST_W-1:0] Instruction,
  output logic              cpu_reset,
  output logic              loading,
  output logic              load_err,
  output logic [8:0]        prog_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  loadState_t        state;
  logic [8:0]        byteCnt;
  logic [8:0]        target;
  logic [TW-1:0]     tmoCnt;
  logic              accept;
  logic [8:0]        cntNext;
  logic [8:0]        lenTarget;
  logic              memWe;
  logic [INST_W-1:0] memData;

  assign accept    = s_valid && s_ready;
  assign cntNext   = byteCnt + 9'd1;
  assign lenTarget = (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
  // load_start outranks a same-cycle transfer, so the byte must not reach memory
  assign memWe     = (state == DATA) && accept && !load_start;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      s_ready   <= 1'b0;
      loading   <= 1'b0;
      load_err  <= 1'b0;
      prog_len  <= 9'd0;
      byteCnt   <= 9'd0;
      target    <= 9'd0;
      tmoCnt    <= '0;
    end else if (load_start) begin
      state     <= LEN;
      cpu_reset <= 1'b1;
      s_ready   <= 1'b1;
      loading   <= 1'b1;
      byteCnt   <= 9'd0;
      tmoCnt    <= '0;
    end else begin
      case (state)
        LEN, DATA: begin
          if (accept) begin
            tmoCnt <= '0;
            if (state == LEN) begin
              target   <= lenTarget;
              byteCnt  <= 9'd0;
              load_err <= 1'b0;
              state    <= DATA;
            end else begin
              byteCnt <= cntNext;
              if (cntNext == target) begin
                state     <= RUN;
                prog_len  <= target;
                cpu_reset <= 1'b0;
                s_ready   <= 1'b0;
                loading   <= 1'b0;
              end
            end
          end else if (tmoCnt == TMO_LAST) begin
            state    <= IDLE;
            load_err <= 1'b1;
            prog_len <= 9'd0;
            s_ready  <= 1'b0;
            loading  <= 1'b0;
            tmoCnt   <= '0;
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  inst_mem #(.DEPTH(DEPTH)) uMem (
    .clk   (clk),
    .we    (memWe),
    .waddr (byteCnt[AW-1:0]),
    .wdata (s_data),
    .raddr (ReadAddress[AW-1:0]),
    .rdata (memData)
  );

  // 9-bit compare so a 256-byte program exposes every address
  assign Instruction = (state == RUN && {1'b0, ReadAddress} < prog_len) ? memData : FILL;

endmodule
